sha_apb_engine_ctrl: RTL and testbench
======================================

// Module: sha_apb_engine_ctrl
// PURPOSE
//  APB slave controlling an external hash core with a parametrised message and digest width.
//  Adds explicit or automatic start, busy and error status, a run-cycle counter, a watchdog
//  timeout and PSLVERR reporting. Sits between the APB interconnect and the hash core.
// PARAMETERS
//  APB_ADDR_WIDTH  12  PADDR width; only PADDR[7:2] is decoded.
//  MSG_WORDS       1   32-bit message words; core message width is 32*MSG_WORDS. Range 1..16.
//  DIG_WORDS       8   32-bit digest words; core digest width is 32*DIG_WORDS. Range 1..16.
//  TIMEOUT         0   Run-cycle limit before abort; 0 disables the watchdog.
// PORTS
//  HCLK           in   1                 Clock.
//  HRESETn        in   1                 Reset: asynchronous, active-low.
//  PADDR          in   APB_ADDR_WIDTH    APB address.
//  PWDATA         in   32                APB write data.
//  PWRITE         in   1                 APB write select.
//  PSEL           in   1                 APB select.
//  PENABLE        in   1                 APB enable.
//  PRDATA         out  32                APB read data.
//  PREADY         out  1                 Tied to 1; every access completes with no wait states.
//  PSLVERR        out  1                 Access error, valid during the access phase.
//  int_o          out  1                 Interrupt: CTRL.int_en & STATUS.done.
//  core_valid_o   out  1                 Held high while the core runs.
//  core_msg_o     out  32*MSG_WORDS      Message to the core. Word 0 occupies the MSBs.
//  core_done_i    in   1                 One-cycle pulse; the digest is valid in that cycle.
//  core_digest_i  in   32*DIG_WORDS      Core digest. Word 0 occupies the MSBs.
// BEHAVIOUR
//  Access: acc = PSEL & PENABLE. wr = acc & PWRITE. rd = acc & ~PWRITE.
//  Register map (byte offsets):
//   CTRL 0x00 RW    bit0 int_en, bit1 auto_start.
//   CMD 0x04 W      Write-1 pulses: bit0 start, bit1 clr_done, bit2 clr_err. Reads return 0.
//   STATUS 0x08 R   bit0 busy, bit1 done, bit2 err, bit3 timeout.
//   CYCLES 0x0C R   Cycle count of the last run.
//   MSG[i] 0x40+4i RW   i < MSG_WORDS.
//   DIG[i] 0x80+4i R    i < DIG_WORDS.
//  Unmapped addresses: reads return 0, writes are ignored, PSLVERR stays 0.
//  PRDATA: combinational when rd, 0 otherwise.
//  Reset: all registers, STATUS and CYCLES are 0. FSM is IDLE. PRDATA, PSLVERR, int_o and
//   core_valid_o are 0.
//  FSM IDLE:
//   Go to RUN on either: CMD write with bit0 set; or write to MSG[MSG_WORDS-1] with auto_start=1.
//   The auto-start MSG write lands in the same edge, so the new data is sent to the core.
//  FSM RUN:
//   core_valid_o=1 and busy=1. The counter is 1 in the first RUN cycle, increments each cycle,
//   and saturates at 0xFFFFFFFF.
//   core_done_i=1: capture the digest into DIG, counter into CYCLES, set done, go to IDLE.
//    core_valid_o drops on the next edge.
//   TIMEOUT!=0 and counter==TIMEOUT with no done in that cycle: set err and timeout, load
//    CYCLES=TIMEOUT, go to IDLE. DIG and done are unchanged.
//   core_done_i is ignored in IDLE.
//  Busy errors: while busy, an MSG write or CMD.start is dropped, PSLVERR=1 in that access
//   phase, and err is set. A CMD write while busy still applies clr_done and clr_err.
//   A CTRL write while busy is legal.
//  Simultaneous events: core done beats clr_done in the same cycle (done ends at 1).
//   A new error beats clr_err. A CMD write with start and clr_done clears done and then starts.
//  DIG and MSG hold their values across runs. Only a completed run updates DIG.
//  Reset mid-run: returns to IDLE immediately and core_valid_o deasserts asynchronously.
//  int_o is level-sensitive and combinational from registers.
// TESTING
//  1. MSG_WORDS=1: write MSG0=0x616263, CMD=1; core model gives done after 64 cycles
//     -> busy for 64 cycles, DIG0..7 = model digest, CYCLES=64, STATUS=0x2.
//  2. CTRL=0x3, MSG_WORDS=2: write MSG0=0xA, then MSG1=0xB -> RUN starts on the MSG1 edge,
//     core_msg_o=0x0000000A_0000000B. After done, int_o=1. Write CMD=0x2 -> int_o=0.
//  3. Write MSG0 during RUN -> PSLVERR=1, MSG0 unchanged, STATUS.err=1.
//     CMD=0x4 -> err=0 while still busy.
//  4. TIMEOUT=10, core never completes -> after 10 RUN cycles: IDLE, STATUS=0xC, CYCLES=10,
//     DIG unchanged.
//  5. core_done_i and a CMD=0x2 write in the same cycle -> done=1.
//     Then assert HRESETn=0 mid-run -> core_valid_o=0 immediately, all registers 0.
//  6. Read 0x3C and 0xC0 -> 0 with PSLVERR=0. Every access shows PREADY=1.

Source files
------------

// File: rtl/sha_apb_engine_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sha_apb_engine_ctrl
// Brief    : APB control/status slave driving an external hash core.
// Revision : 1.0
// ============================================================================
module sha_apb_engine_ctrl #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int MSG_WORDS      = 1,
  parameter int DIG_WORDS      = 8,
  parameter int TIMEOUT        = 0
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      int_o,
  output logic                      core_valid_o,
  output logic [32*MSG_WORDS-1:0]   core_msg_o,
  input  logic                      core_done_i,
  input  logic [32*DIG_WORDS-1:0]   core_digest_i
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [5:0]  C_IDX_CTRL   = 6'd0;
  localparam logic [5:0]  C_IDX_CMD    = 6'd1;
  localparam logic [5:0]  C_IDX_STATUS = 6'd2;
  localparam logic [5:0]  C_IDX_CYCLES = 6'd3;
  localparam logic [5:0]  C_IDX_LAST   = 6'(16 + MSG_WORDS - 1);
  localparam logic [4:0]  C_MSG_N      = 5'(MSG_WORDS);
  localparam logic [4:0]  C_DIG_N      = 5'(DIG_WORDS);
  localparam logic [31:0] C_TIMEOUT    = 32'(TIMEOUT);

  state_t      r_state;
  logic        r_valid, r_int_en, r_auto, r_done, r_err, r_tmo;
  logic [31:0] r_cnt, r_cycles;
  logic [31:0] r_msg [MSG_WORDS];
  logic [31:0] r_dig [DIG_WORDS];

  logic        w_acc, w_wr, w_rd, w_msg_hit, w_dig_hit, w_busy_err;
  logic        w_start, w_clr_done, w_clr_err, w_unused;
  logic [5:0]  w_idx;
  logic [31:0] w_msg_rd, w_dig_rd, w_rdata;

  assign w_idx      = PADDR[7:2];
  assign w_unused   = ^{PADDR[APB_ADDR_WIDTH-1:8], PADDR[1:0]};
  assign w_acc      = PSEL & PENABLE;
  assign w_wr       = w_acc & PWRITE;
  assign w_rd       = w_acc & ~PWRITE;
  assign w_msg_hit  = (w_idx[5:4] == 2'b01) && ({1'b0, w_idx[3:0]} < C_MSG_N);
  assign w_dig_hit  = (w_idx[5:4] == 2'b10) && ({1'b0, w_idx[3:0]} < C_DIG_N);
  assign w_clr_done = w_wr && (w_idx == C_IDX_CMD) && PWDATA[1];
  assign w_clr_err  = w_wr && (w_idx == C_IDX_CMD) && PWDATA[2];
  assign w_start    = w_wr && (((w_idx == C_IDX_CMD) && PWDATA[0]) ||
                               ((w_idx == C_IDX_LAST) && r_auto));
  // Message updates and new starts are refused while the core is running
  assign w_busy_err = w_wr && r_valid && (w_msg_hit || ((w_idx == C_IDX_CMD) && PWDATA[0]));

  assign PSLVERR      = w_busy_err;
  assign PREADY       = 1'b1;
  assign int_o        = r_int_en & r_done;
  assign core_valid_o = r_valid;

  for (genvar g = 0; g < MSG_WORDS; g++) begin : g_msg
    assign core_msg_o[32*(MSG_WORDS-g)-1 -: 32] = r_msg[g];
  end

  always_comb begin
    w_msg_rd = '0;
    w_dig_rd = '0;
    for (int i = 0; i < MSG_WORDS; i++)
      if (w_idx[3:0] == 4'(i)) w_msg_rd = r_msg[i];
    for (int i = 0; i < DIG_WORDS; i++)
      if (w_idx[3:0] == 4'(i)) w_dig_rd = r_dig[i];
    w_rdata = '0;
    case (w_idx)
      C_IDX_CTRL:   w_rdata = {30'd0, r_auto, r_int_en};
      C_IDX_STATUS: w_rdata = {28'd0, r_tmo, r_err, r_done, r_valid};
      C_IDX_CYCLES: w_rdata = r_cycles;
      default: begin
        if (w_msg_hit)      w_rdata = w_msg_rd;
        else if (w_dig_hit) w_rdata = w_dig_rd;
      end
    endcase
    PRDATA = w_rd ? w_rdata : 32'd0;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state  <= S_IDLE;
      r_valid  <= 1'b0;
      r_int_en <= 1'b0;
      r_auto   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_tmo    <= 1'b0;
      r_cnt    <= '0;
      r_cycles <= '0;
      for (int i = 0; i < MSG_WORDS; i++) r_msg[i] <= '0;
      for (int i = 0; i < DIG_WORDS; i++) r_dig[i] <= '0;
    end else begin
      if (w_wr && (w_idx == C_IDX_CTRL)) {r_auto, r_int_en} <= PWDATA[1:0];
      // Later assignments win: completion beats clr_done, a new error beats clr_err
      if (w_clr_done) r_done <= 1'b0;
      if (w_clr_err) begin
        r_err <= 1'b0;
        r_tmo <= 1'b0;
      end
      if (w_busy_err) r_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          for (int i = 0; i < MSG_WORDS; i++)
            if (w_wr && w_msg_hit && (w_idx[3:0] == 4'(i))) r_msg[i] <= PWDATA;
          if (w_start) begin
            r_state <= S_RUN;
            r_valid <= 1'b1;
            r_cnt   <= 32'd1;
          end
        end
        S_RUN: begin
          if (core_done_i) begin
            for (int i = 0; i < DIG_WORDS; i++)
              r_dig[i] <= core_digest_i[32*(DIG_WORDS-i)-1 -: 32];
            r_cycles <= r_cnt;
            r_done   <= 1'b1;
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
          end else if ((C_TIMEOUT != 32'd0) && (r_cnt == C_TIMEOUT)) begin
            r_err    <= 1'b1;
            r_tmo    <= 1'b1;
            r_cycles <= C_TIMEOUT;
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
          end else if (r_cnt != 32'hFFFF_FFFF) begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha_apb_engine_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha_apb_engine_ctrl
// Brief    : Self-checking bench for sha_apb_engine_ctrl (two configurations).
// Revision : 1.0
// ============================================================================
module tb_sha_apb_engine_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [11:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0;
  logic        PENABLE = 1'b0;
  logic [1:0]  psel = '0;
  logic [1:0][31:0] prdata;
  logic [1:0]  pready, pslverr, int_v, valid;
  logic [31:0] msg_a;
  logic [63:0] msg_b;
  logic [1:0]  done_auto = '0, done_man = '0, cdone;
  logic [255:0] digest = '0;
  int          lat [2] = '{0, 0};
  int          ccnt [2] = '{0, 0};
  int          n_tests = 0, n_fail = 0;

  // Reference state: what the register file must hold after each edge
  bit          m_ien [2], m_auto [2], m_run [2], m_done [2], m_err [2], m_to [2];
  logic [31:0] m_cyc [2], m_cnt [2];
  logic [31:0] m_msg [2][16];
  logic [31:0] m_dig [2][8];

  always #5 HCLK = ~HCLK;
  assign cdone = done_auto | done_man;

  sha_apb_engine_ctrl #(.APB_ADDR_WIDTH(12), .MSG_WORDS(1), .DIG_WORDS(8), .TIMEOUT(0)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(psel[0]), .PENABLE(PENABLE), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .int_o(int_v[0]), .core_valid_o(valid[0]), .core_msg_o(msg_a),
    .core_done_i(cdone[0]), .core_digest_i(digest));

  sha_apb_engine_ctrl #(.APB_ADDR_WIDTH(12), .MSG_WORDS(2), .DIG_WORDS(8), .TIMEOUT(10)) u_dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(psel[1]), .PENABLE(PENABLE), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .int_o(int_v[1]), .core_valid_o(valid[1]), .core_msg_o(msg_b),
    .core_done_i(cdone[1]), .core_digest_i(digest));

  function automatic int mw(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int tmo(input int d);
    return (d == 0) ? 0 : 10;
  endfunction

  function automatic bit exp_err(input int d);
    int idx = int'(PADDR[7:2]);
    if (!(psel[d] && PENABLE && PWRITE && m_run[d])) return 1'b0;
    return (idx >= 16 && idx < 16 + mw(d)) || (idx == 1 && PWDATA[0]);
  endfunction

  function automatic logic [31:0] exp_rd(input int d);
    int idx = int'(PADDR[7:2]);
    if (!(psel[d] && PENABLE && !PWRITE)) return 32'd0;
    if (idx == 0) return {30'd0, m_auto[d], m_ien[d]};
    if (idx == 2) return {28'd0, m_to[d], m_err[d], m_done[d], m_run[d]};
    if (idx == 3) return m_cyc[d];
    if (idx >= 16 && idx < 16 + mw(d)) return m_msg[d][idx-16];
    if (idx >= 32 && idx < 40) return m_dig[d][idx-32];
    return 32'd0;
  endfunction

  task automatic model_step();
    bit wr, berr, start, fin;
    int idx;
    for (int d = 0; d < 2; d++) begin
      if (!HRESETn) begin
        m_ien[d] = 0; m_auto[d] = 0; m_run[d] = 0; m_done[d] = 0; m_err[d] = 0; m_to[d] = 0;
        m_cyc[d] = 0; m_cnt[d] = 0;
        for (int i = 0; i < 16; i++) m_msg[d][i] = 0;
        for (int i = 0; i < 8; i++) m_dig[d][i] = 0;
      end else begin
        wr    = psel[d] && PENABLE && PWRITE;
        idx   = int'(PADDR[7:2]);
        berr  = exp_err(d);
        start = !m_run[d] && wr && ((idx == 1 && PWDATA[0]) || (idx == 15 + mw(d) && m_auto[d]));
        fin   = m_run[d] && cdone[d];
        if (wr && idx == 0) begin m_ien[d] = PWDATA[0]; m_auto[d] = PWDATA[1]; end
        if (wr && !m_run[d] && idx >= 16 && idx < 16 + mw(d)) m_msg[d][idx-16] = PWDATA;
        if (wr && idx == 1 && PWDATA[1]) m_done[d] = 0;
        if (wr && idx == 1 && PWDATA[2]) begin m_err[d] = 0; m_to[d] = 0; end
        if (berr) m_err[d] = 1;
        if (start) begin
          m_run[d] = 1; m_cnt[d] = 1;
        end else if (fin) begin
          for (int i = 0; i < 8; i++) m_dig[d][i] = digest[255-32*i -: 32];
          m_cyc[d] = m_cnt[d]; m_done[d] = 1; m_run[d] = 0;
        end else if (m_run[d] && tmo(d) != 0 && m_cnt[d] == 32'(tmo(d))) begin
          m_err[d] = 1; m_to[d] = 1; m_cyc[d] = 32'(tmo(d)); m_run[d] = 0;
        end else if (m_run[d] && m_cnt[d] != 32'hFFFF_FFFF) begin
          m_cnt[d] = m_cnt[d] + 1;
        end
      end
    end
  endtask

  initial begin
    model_step();
    forever begin
      @(posedge HCLK or negedge HRESETn);
      model_step();
    end
  end

  // Core stand-in: pulses done after lat[d] valid cycles (lat 0 = never completes)
  initial begin
    forever begin
      @(negedge HCLK);
      for (int d = 0; d < 2; d++) begin
        if (valid[d]) begin
          ccnt[d]++;
          done_auto[d] = (lat[d] != 0) && (ccnt[d] == lat[d]);
        end else begin
          ccnt[d] = 0;
          done_auto[d] = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [99:0] act, exp;
    forever begin
      @(negedge HCLK);
      #2;
      for (int d = 0; d < 2; d++) begin
        act = {prdata[d], pslverr[d], pready[d], int_v[d], valid[d],
               (d == 0) ? {32'd0, msg_a} : msg_b};
        exp = {exp_rd(d), exp_err(d), 1'b1, m_ien[d] & m_done[d], m_run[d],
               (d == 0) ? {32'd0, m_msg[0][0]} : {m_msg[1][0], m_msg[1][1]}};
        n_tests++;
        if (act !== exp) begin
          n_fail++;
          if (n_fail < 30)
            $display("FAIL cycle_dut%0d t=%0t got=%h expected=%h", d, $time, act, exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic xfer(input int d, input bit wr, input logic [11:0] addr, input logic [31:0] data,
                      input bit pdone, output logic [31:0] rdata, output logic err);
    @(negedge HCLK);
    psel = '0; psel[d] = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    @(negedge HCLK);
    PENABLE = 1'b1; done_man[d] = pdone;
    #1;
    rdata = prdata[d];
    err   = pslverr[d];
    chk("pready", {63'd0, pready[d]}, 64'd1);
    @(negedge HCLK);
    psel = '0; PENABLE = 1'b0; PWRITE = 1'b0; done_man[d] = 1'b0;
  endtask

  task automatic wr(input int d, input logic [11:0] a, input logic [31:0] v);
    logic [31:0] r; logic e;
    xfer(d, 1'b1, a, v, 1'b0, r, e);
  endtask

  task automatic wr_err(input string name, input int d, input logic [11:0] a,
                        input logic [31:0] v, input logic exp_e);
    logic [31:0] r; logic e;
    xfer(d, 1'b1, a, v, 1'b0, r, e);
    chk(name, {63'd0, e}, {63'd0, exp_e});
  endtask

  task automatic rd_chk(input string name, input int d, input logic [11:0] a, input logic [31:0] v);
    logic [31:0] r; logic e;
    xfer(d, 1'b0, a, 32'd0, 1'b0, r, e);
    chk(name, {32'd0, r}, {32'd0, v});
  endtask

  task automatic wait_idle(input int d, output int n);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (!valid[d]) return;
      n++;
      @(negedge HCLK);
    end
    n_tests++; n_fail++;
    $display("FAIL wait_idle dut%0d got=busy_after_%0d expected=idle", d, n);
  endtask

  task automatic set_digest(input logic [31:0] base);
    for (int i = 0; i < 8; i++) digest[255-32*i -: 32] = base + 32'(i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] r;
    logic e;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;

    // Reset state
    rd_chk("rst_status0", 0, 12'h008, 32'h0);
    rd_chk("rst_ctrl1", 1, 12'h000, 32'h0);
    rd_chk("rst_cycles1", 1, 12'h00C, 32'h0);
    chk("rst_valid", {62'd0, valid}, 64'd0);

    // Explicit start, 64-cycle core
    lat[0] = 64;
    set_digest(32'h1000_0000);
    wr(0, 12'h040, 32'h0061_6263);
    wr(0, 12'h004, 32'h1);
    #1;
    chk("t1_msg", {32'd0, msg_a}, 64'h0061_6263);
    wait_idle(0, n);
    chk("t1_busy_cycles", 64'(n), 64'd64);
    rd_chk("t1_cycles", 0, 12'h00C, 32'd64);
    rd_chk("t1_status", 0, 12'h008, 32'h2);
    rd_chk("t1_dig0", 0, 12'h080, 32'h1000_0000);
    rd_chk("t1_dig7", 0, 12'h09C, 32'h1000_0007);

    // Auto start on the last message word
    lat[1] = 5;
    set_digest(32'h2000_0000);
    wr(1, 12'h000, 32'h3);
    wr(1, 12'h040, 32'hA);
    #1;
    chk("t2_no_start_msg0", {63'd0, valid[1]}, 64'd0);
    wr(1, 12'h044, 32'hB);
    #1;
    chk("t2_started", {63'd0, valid[1]}, 64'd1);
    chk("t2_msg", msg_b, 64'h0000_000A_0000_000B);
    wait_idle(1, n);
    chk("t2_busy_cycles", 64'(n), 64'd5);
    chk("t2_int_set", {63'd0, int_v[1]}, 64'd1);
    rd_chk("t2_status", 1, 12'h008, 32'h2);
    rd_chk("t2_dig3", 1, 12'h08C, 32'h2000_0003);
    wr(1, 12'h004, 32'h2);
    #1;
    chk("t2_int_clr", {63'd0, int_v[1]}, 64'd0);

    // Busy errors on a core that never completes
    lat[0] = 0;
    wr(0, 12'h004, 32'h1);
    wr_err("t3_msg_pslverr", 0, 12'h040, 32'h55, 1'b1);
    rd_chk("t3_status_err", 0, 12'h008, 32'h7);
    rd_chk("t3_msg_kept", 0, 12'h040, 32'h0061_6263);
    wr_err("t3_clr_err_ok", 0, 12'h004, 32'h4, 1'b0);
    rd_chk("t3_status_clr", 0, 12'h008, 32'h3);
    wr_err("t3_start_pslverr", 0, 12'h004, 32'h5, 1'b1);
    rd_chk("t3_err_beats_clr", 0, 12'h008, 32'h7);

    // Watchdog abort
    lat[1] = 0;
    set_digest(32'hBAD0_0000);
    wr(1, 12'h004, 32'h1);
    wait_idle(1, n);
    chk("t4_busy_cycles", 64'(n), 64'd10);
    rd_chk("t4_status", 1, 12'h008, 32'hC);
    rd_chk("t4_cycles", 1, 12'h00C, 32'd10);
    rd_chk("t4_dig0_kept", 1, 12'h080, 32'h2000_0000);
    rd_chk("t4_dig7_kept", 1, 12'h09C, 32'h2000_0007);

    // Core done together with clr_done, then reset mid-run
    xfer(0, 1'b1, 12'h004, 32'h2, 1'b1, r, e);
    rd_chk("t5_done_wins", 0, 12'h008, 32'h6);
    wr(0, 12'h004, 32'h1);
    repeat (2) @(negedge HCLK);
    #3;
    HRESETn = 1'b0;
    #1;
    chk("t5_valid_async", {63'd0, valid[0]}, 64'd0);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    rd_chk("t5_status_rst", 0, 12'h008, 32'h0);
    rd_chk("t5_cycles_rst", 0, 12'h00C, 32'h0);
    rd_chk("t5_msg_rst", 0, 12'h040, 32'h0);
    rd_chk("t5_dig_rst", 0, 12'h080, 32'h0);
    rd_chk("t5_ctrl1_rst", 1, 12'h000, 32'h0);

    // Unmapped and write-only locations
    wr(0, 12'h040, 32'h1234_5678);
    xfer(0, 1'b0, 12'h03C, 32'd0, 1'b0, r, e);
    chk("t6_rd_3c", {32'd0, r}, 64'd0);
    chk("t6_err_3c", {63'd0, e}, 64'd0);
    xfer(0, 1'b0, 12'h0C0, 32'd0, 1'b0, r, e);
    chk("t6_rd_c0", {32'd0, r}, 64'd0);
    chk("t6_err_c0", {63'd0, e}, 64'd0);
    rd_chk("t6_msg1_unmapped", 0, 12'h044, 32'h0);
    rd_chk("t6_cmd_reads0", 0, 12'h004, 32'h0);
    wr_err("t6_wr_3c", 0, 12'h03C, 32'hFFFF_FFFF, 1'b0);
    rd_chk("t6_msg0", 0, 12'h040, 32'h1234_5678);

    repeat (2) @(negedge HCLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
